// File: rtl/branch_issue_ctrl_pkg.sv
// rtl/branch_issue_ctrl_pkg.sv - shared types for the branch issue controller
package branch_issue_ctrl_pkg;

    localparam int BIC_N_REQ_DEF       = 4;
    localparam int BIC_RECOVER_CYC_DEF = 2;

    typedef enum logic {
        BIC_RUN,
        BIC_RECOVER
    } BIC_STATE;

    typedef enum logic [1:0] {
        BR_NOTHING = 2'd0,
        BR_CLEAR   = 2'd1,
        BR_SQUASH  = 2'd2
    } BR_TASK;

    typedef struct packed {
        logic [15:0] pc;
        logic [7:0]  tag;
    } ISSUE_PACKET;

endpackage

// File: rtl/branch_issue_ctrl_if.sv
// rtl/branch_issue_ctrl_if.sv - RS/FU handshake bundle of the branch issue controller
interface branch_issue_ctrl_if #(parameter int N_REQ = 4) ();
    import branch_issue_ctrl_pkg::*;

    logic [N_REQ-1:0] req_valid;
    logic [N_REQ-1:0] req_alloc;
    ISSUE_PACKET      req_pack [N_REQ];
    logic             stall;
    BR_TASK           fu_br_task;
    logic             fu_data_ready;
    logic [N_REQ-1:0] grant;
    logic             fu_rd_en;
    ISSUE_PACKET      fu_is_pack;
    logic             kill_issue;
    logic             recovering;

    modport master (
        output req_valid, req_alloc, req_pack, stall, fu_br_task, fu_data_ready,
        input  grant, fu_rd_en, fu_is_pack, kill_issue, recovering
    );

    modport slave (
        input  req_valid, req_alloc, req_pack, stall, fu_br_task, fu_data_ready,
        output grant, fu_rd_en, fu_is_pack, kill_issue, recovering
    );

endinterface

// File: rtl/branch_issue_ctrl_age_matrix_picker.sv
// rtl/branch_issue_ctrl_age_matrix_picker.sv - age matrix with oldest-ready one-hot select
module age_matrix_picker #(
    parameter int N = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] req_valid,
    input  logic [N-1:0] req_alloc,
    output logic [N-1:0] pick
);

    logic [N-1:0] older_q [N];
    logic [N-1:0] older_d [N];
    logic [N-1:0] blocked;
    logic [N-1:0] eligible;

    // older[i][j]: slot i older than slot j; a fresh alloc is younger than everything,
    // and among simultaneous allocs the lower index wins.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                older_d[i][j] = older_q[i][j];
                if (i == j) begin
                    older_d[i][j] = 1'b0;
                end else if (req_alloc[i] && req_alloc[j]) begin
                    older_d[i][j] = (i < j);
                end else if (req_alloc[i]) begin
                    older_d[i][j] = 1'b0;
                end else if (req_alloc[j]) begin
                    older_d[i][j] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        blocked = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                blocked[i] = blocked[i] | (req_valid[j] & older_q[j][i]);
            end
        end
        eligible = req_valid & ~blocked;
    end

    // Lowest-index tie-break only matters while the matrix holds no order (after reset).
    assign pick = eligible & (~eligible + N'(1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                older_q[i] <= '0;
            end
        end else begin
            older_q <= older_d;
        end
    end

    always @(posedge clock) begin
        if (reset) begin
            assert (!(|(req_alloc & req_valid)))
            else $fatal(1, "age_matrix_picker: alloc on a slot holding a valid branch");
        end
    end

endmodule

// File: rtl/branch_issue_ctrl.sv
// rtl/branch_issue_ctrl.sv - schedules the single branch FU and blocks issue during squash recovery
module branch_issue_ctrl #(
    parameter int N_REQ       = 4,
    parameter int RECOVER_CYC = 2
) (
    input logic          clock,
    input logic          reset,
    branch_issue_ctrl_if.slave bus
);
    import branch_issue_ctrl_pkg::*;

    localparam int CW = $clog2(RECOVER_CYC + 1);

    BIC_STATE         state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ready_q;
    logic [N_REQ-1:0] pick;
    logic [N_REQ-1:0] grant;
    logic             rd_en;
    logic             kill;
    logic             recovering;
    logic             squash;
    ISSUE_PACKET      pack;

    age_matrix_picker #(.N(N_REQ)) u_picker (
        .clock     (clock),
        .reset     (reset),
        .req_valid (bus.req_valid),
        .req_alloc (bus.req_alloc),
        .pick      (pick)
    );

    // ready_q holds every output quiet through the first cycle after reset release.
    assign squash = ready_q && bus.fu_data_ready && (bus.fu_br_task == BR_SQUASH);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        grant      = '0;
        rd_en      = 1'b0;
        kill       = 1'b0;
        recovering = 1'b0;
        pack       = '0;
        case (state_q)
            BIC_RUN: begin
                if (ready_q && !bus.stall && (|bus.req_valid)) begin
                    grant = pick;
                    rd_en = 1'b1;
                    for (int i = 0; i < N_REQ; i++) begin
                        if (pick[i]) begin
                            pack = bus.req_pack[i];
                        end
                    end
                end
                if (squash) begin
                    kill    = rd_en;
                    cnt_d   = CW'(RECOVER_CYC - 1);
                    state_d = BIC_RECOVER;
                end
            end
            BIC_RECOVER: begin
                recovering = 1'b1;
                if (cnt_q == '0) begin
                    state_d = BIC_RUN;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = BIC_RUN;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= BIC_RUN;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= 1'b1;
        end
    end

    always @(posedge clock) begin
        if (reset && state_q == BIC_RECOVER) begin
            assert (!bus.fu_data_ready)
            else $error("branch_issue_ctrl: FU result while recovering, ignored");
        end
    end

    assign bus.grant      = grant;
    assign bus.fu_rd_en   = rd_en;
    assign bus.fu_is_pack = pack;
    assign bus.kill_issue = kill;
    assign bus.recovering = recovering;

endmodule

// File: tb/tb_branch_issue_ctrl.sv
// tb/tb_branch_issue_ctrl.sv - directed self-checking bench for branch_issue_ctrl
module tb_branch_issue_ctrl;
    import branch_issue_ctrl_pkg::*;

    logic clock;
    logic reset;
    int   total;
    int   passed;

    branch_issue_ctrl_if #(.N_REQ(4)) bus ();

    branch_issue_ctrl #(.N_REQ(4), .RECOVER_CYC(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic expect_out(input string tag, input logic [3:0] g, input logic rd,
                              input logic k, input logic rc);
        chk({tag, ".grant"},      32'(bus.grant),      32'(g));
        chk({tag, ".fu_rd_en"},   32'(bus.fu_rd_en),   32'(rd));
        chk({tag, ".kill_issue"}, 32'(bus.kill_issue), 32'(k));
        chk({tag, ".recovering"}, 32'(bus.recovering), 32'(rc));
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        reset  = 1'b0;
        bus.req_valid     = 4'b0001;
        bus.req_alloc     = 4'b0000;
        bus.stall         = 1'b0;
        bus.fu_br_task    = BR_NOTHING;
        bus.fu_data_ready = 1'b0;
        bus.req_pack[0] = '{pc: 16'h1000, tag: 8'hA0};
        bus.req_pack[1] = '{pc: 16'h1001, tag: 8'hA1};
        bus.req_pack[2] = '{pc: 16'h1002, tag: 8'hA2};
        bus.req_pack[3] = '{pc: 16'h1003, tag: 8'hA3};

        // in reset with a valid request: everything quiet
        #3;
        expect_out("rst", 4'b0000, 1'b0, 1'b0, 1'b0);
        chk("rst.pack", 32'(bus.fu_is_pack), 32'h0);
        cyc();
        reset = 1'b1;
        bus.req_valid = 4'b0000;

        // 1: idle after release
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            expect_out("t1.idle", 4'b0000, 1'b0, 1'b0, 1'b0);
            cyc();
        end

        // 2: alloc 2, 0, 3 -> issue order 2, 0, 3
        bus.req_alloc = 4'b0100; cyc();
        bus.req_alloc = 4'b0001; cyc();
        bus.req_alloc = 4'b1000; cyc();
        bus.req_alloc = 4'b0000;
        bus.req_valid = 4'b1101;
        @(negedge clock);
        expect_out("t2.first", 4'b0100, 1'b1, 1'b0, 1'b0);
        chk("t2.first.pack", 32'(bus.fu_is_pack), 32'h1002A2);
        cyc();
        bus.req_valid = 4'b1001;
        bus.fu_data_ready = 1'b1; bus.fu_br_task = BR_CLEAR;
        @(negedge clock);
        expect_out("t2.second", 4'b0001, 1'b1, 1'b0, 1'b0);
        chk("t2.second.pack", 32'(bus.fu_is_pack), 32'h1000A0);
        cyc();
        bus.req_valid = 4'b1000;
        @(negedge clock);
        expect_out("t2.third", 4'b1000, 1'b1, 1'b0, 1'b0);
        chk("t2.third.pack", 32'(bus.fu_is_pack), 32'h1003A3);
        cyc();
        bus.req_valid = 4'b0000;
        @(negedge clock);
        expect_out("t2.empty", 4'b0000, 1'b0, 1'b0, 1'b0);
        chk("t2.empty.pack", 32'(bus.fu_is_pack), 32'h0);
        cyc();
        bus.fu_data_ready = 1'b0; bus.fu_br_task = BR_NOTHING;

        // 3: simultaneous alloc of 1 and 3 -> 1 older
        bus.req_alloc = 4'b1010; cyc();
        bus.req_alloc = 4'b0000;
        bus.req_valid = 4'b1010;
        @(negedge clock);
        expect_out("t3.first", 4'b0010, 1'b1, 1'b0, 1'b0);
        cyc();
        bus.req_valid = 4'b1000;
        bus.fu_data_ready = 1'b1; bus.fu_br_task = BR_CLEAR;
        @(negedge clock);
        expect_out("t3.second", 4'b1000, 1'b1, 1'b0, 1'b0);
        cyc();
        bus.req_valid = 4'b0000;
        cyc();
        bus.fu_data_ready = 1'b0; bus.fu_br_task = BR_NOTHING;

        // 4: squash kills the same-cycle issue, then two recovery cycles
        bus.req_alloc = 4'b0100; cyc();
        bus.req_alloc = 4'b0001; cyc();
        bus.req_alloc = 4'b0010; cyc();
        bus.req_alloc = 4'b0000;
        bus.req_valid = 4'b0011;
        @(negedge clock);
        expect_out("t4.t0", 4'b0001, 1'b1, 1'b0, 1'b0);
        cyc();
        bus.req_valid = 4'b0010;
        bus.fu_data_ready = 1'b1; bus.fu_br_task = BR_SQUASH;
        @(negedge clock);
        expect_out("t4.t1", 4'b0010, 1'b1, 1'b1, 1'b0);
        chk("t4.t1.pack", 32'(bus.fu_is_pack), 32'h1001A1);
        cyc();
        bus.req_valid = 4'b0100;
        bus.fu_data_ready = 1'b0; bus.fu_br_task = BR_NOTHING;
        @(negedge clock);
        expect_out("t4.t2", 4'b0000, 1'b0, 1'b0, 1'b1);
        cyc();
        @(negedge clock);
        expect_out("t4.t3", 4'b0000, 1'b0, 1'b0, 1'b1);
        cyc();
        @(negedge clock);
        expect_out("t4.t4", 4'b0100, 1'b1, 1'b0, 1'b0);
        cyc();
        bus.req_valid = 4'b0000;
        bus.fu_data_ready = 1'b1; bus.fu_br_task = BR_CLEAR;
        @(negedge clock);
        expect_out("t4.t5", 4'b0000, 1'b0, 1'b0, 1'b0);
        cyc();
        bus.fu_data_ready = 1'b0; bus.fu_br_task = BR_NOTHING;

        // 5: stall holds grants; CLEAR results change nothing
        bus.req_alloc = 4'b0100; cyc();
        bus.req_alloc = 4'b0000;
        bus.req_valid = 4'b0100;
        bus.stall = 1'b1;
        bus.fu_data_ready = 1'b1; bus.fu_br_task = BR_CLEAR;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            expect_out("t5.stall", 4'b0000, 1'b0, 1'b0, 1'b0);
            cyc();
        end
        bus.stall = 1'b0;
        bus.fu_data_ready = 1'b0; bus.fu_br_task = BR_NOTHING;
        @(negedge clock);
        expect_out("t5.release", 4'b0100, 1'b1, 1'b0, 1'b0);
        chk("t5.release.pack", 32'(bus.fu_is_pack), 32'h1002A2);
        cyc();
        bus.req_valid = 4'b0000;
        bus.fu_data_ready = 1'b1; bus.fu_br_task = BR_CLEAR;
        cyc();
        bus.fu_data_ready = 1'b0; bus.fu_br_task = BR_NOTHING;

        // 6: reset during recovery (counter=1)
        bus.req_alloc = 4'b1000; cyc();
        bus.req_alloc = 4'b0000;
        bus.req_valid = 4'b1000;
        @(negedge clock);
        expect_out("t6.issue", 4'b1000, 1'b1, 1'b0, 1'b0);
        cyc();
        bus.req_valid = 4'b0000;
        bus.fu_data_ready = 1'b1; bus.fu_br_task = BR_SQUASH;
        @(negedge clock);
        expect_out("t6.squash", 4'b0000, 1'b0, 1'b0, 1'b0);
        cyc();
        bus.fu_data_ready = 1'b0; bus.fu_br_task = BR_NOTHING;
        bus.req_valid = 4'b0001;
        #1;
        expect_out("t6.recover", 4'b0000, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        #1;
        expect_out("t6.async", 4'b0000, 1'b0, 1'b0, 1'b0);
        cyc();
        reset = 1'b1;
        @(negedge clock);
        expect_out("t6.first", 4'b0000, 1'b0, 1'b0, 1'b0);
        cyc();
        @(negedge clock);
        expect_out("t6.second", 4'b0001, 1'b1, 1'b0, 1'b0);
        chk("t6.second.pack", 32'(bus.fu_is_pack), 32'h1000A0);
        cyc();
        bus.req_valid = 4'b0000;
        cyc();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
